// File: rtl/pc_redirect_unit_if.sv
// pc_redirect_unit_if
//   Bundles the redirect requests going into the PC redirect unit and the
//   fetch-side results coming back out of it.
//   Requests (master -> slave):
//     stall, branch_taken, branch_target, jump, jump_target
//   Results  (slave -> master):
//     pc, pc_valid, flush, misalign
//     taken_cnt, jump_cnt (only when BRANCH_STATS_EN is defined)
//   Optional macro: BRANCH_STATS_EN adds the redirect statistics counters.
interface pc_redirect_unit_if #(
  parameter int PC_W = 32
);
  logic            stall;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic            jump;
  logic [PC_W-1:0] jump_target;
  logic [PC_W-1:0] pc;
  logic            pc_valid;
  logic            flush;
  logic            misalign;
`ifdef BRANCH_STATS_EN
  logic [15:0]     taken_cnt;
  logic [15:0]     jump_cnt;
`endif

  // Pipeline side: raises stalls and redirect requests, observes fetch state.
  modport master (
    output stall, branch_taken, branch_target, jump, jump_target,
`ifdef BRANCH_STATS_EN
    input  taken_cnt, jump_cnt,
`endif
    input  pc, pc_valid, flush, misalign
  );

  // PC redirect unit side.
  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target,
`ifdef BRANCH_STATS_EN
    output taken_cnt, jump_cnt,
`endif
    output pc, pc_valid, flush, misalign
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit
//   Owns the program counter. It steps the fetch address through a one-cycle
//   boot state, sequential +4 advance, redirects from an EX branch or ID jump,
//   and a wrong-path squash window of FLUSH_CYCLES non-stalled cycles.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - asynchronous active-high reset
//     bus  - pc_redirect_unit_if.slave
//            in : stall, branch_taken, branch_target, jump, jump_target
//            out: pc, pc_valid, flush, misalign (+ taken_cnt, jump_cnt)
//   Parameters: PC_W, RESET_PC, FLUSH_CYCLES (1..7).
//   Optional macro: BRANCH_STATS_EN adds saturating 16-bit counters of
//   accepted branch and jump redirects.
//   Every output is registered; there is no input-to-output combinational path.
module pc_redirect_unit #(
  parameter int              PC_W         = 32,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  pc_redirect_unit_if.slave  bus
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Counter reload: the redirect edge itself starts the first flush cycle.
  localparam logic [2:0]      FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);

  logic [1:0]      state;
  logic [2:0]      flush_cnt;
  logic [PC_W-1:0] pc_q;
  logic            valid_q;
  logic            flush_q;
  logic            mis_q;

  logic            redirect;
  logic [PC_W-1:0] redirect_target;

  // Redirects are only honoured in RUN; in BOOT and FLUSH the requests come
  // from squashed or nonexistent instructions. The older EX branch wins.
  always_comb begin
    redirect        = 1'b0;
    redirect_target = bus.jump_target;
    if (state == ST_RUN) begin
      redirect = bus.branch_taken | bus.jump;
    end
    if (bus.branch_taken) begin
      redirect_target = bus.branch_target;
    end
  end

  // PC sequencing. A redirect overrides stall; stall otherwise freezes both
  // the PC and the flush countdown. FLUSH exits on the edge that consumes
  // the last counted cycle, so flush is high for FLUSH_CYCLES active cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_BOOT;
      flush_cnt <= 3'd0;
      pc_q      <= RESET_PC;
      valid_q   <= 1'b0;
      flush_q   <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      mis_q <= 1'b0;
      case (state)
        ST_BOOT: begin
          state   <= ST_RUN;
          valid_q <= 1'b1;
        end
        ST_RUN: begin
          if (redirect) begin
            pc_q      <= {redirect_target[PC_W-1:2], 2'b00};
            mis_q     <= |redirect_target[1:0];
            flush_q   <= 1'b1;
            flush_cnt <= FLUSH_INIT;
            state     <= ST_FLUSH;
          end else if (!bus.stall) begin
            pc_q <= pc_q + PC_STEP;
          end
        end
        ST_FLUSH: begin
          if (!bus.stall) begin
            pc_q <= pc_q + PC_STEP;
            if (flush_cnt == 3'd0) begin
              flush_q <= 1'b0;
              state   <= ST_RUN;
            end else begin
              flush_cnt <= flush_cnt - 3'd1;
            end
          end
        end
        default: begin
          state   <= ST_BOOT;
          flush_q <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_valid = valid_q;
  assign bus.flush    = flush_q;
  assign bus.misalign = mis_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_q;
  logic [15:0] jump_q;

  // Only redirects actually taken are counted, attributed by priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_q <= 16'd0;
      jump_q  <= 16'd0;
    end else if (redirect) begin
      if (bus.branch_taken) begin
        if (taken_q != 16'hFFFF) taken_q <= taken_q + 16'd1;
      end else begin
        if (jump_q != 16'hFFFF) jump_q <= jump_q + 16'd1;
      end
    end
  end

  assign bus.taken_cnt = taken_q;
  assign bus.jump_cnt  = jump_q;
`endif

endmodule
